// File: rtl/adt7310_scheduler.sv
// ---------------------------------------------------------------------------
// adt7310_scheduler
//
// Periodically triggers an ADT7310 SPI transaction FSM, compares each new
// temperature reading against the last reported one and raises a one-cycle
// CPU interrupt when the reading moved by more than a threshold (or when it
// is the first reading after reset or re-enable).
//
// Ports
//   Clk_i                 system clock, rising edge
//   Reset_i               asynchronous active-high reset; the SPI FSM is
//                         expected to be reset from the same source
//   Enable_i              1 runs periodic measurements, 0 parks the block
//   CpuIntr_o             registered one-cycle pulse: new value reported
//   SensorValue_o         last reported value {Byte1,Byte0}, two's complement
//   SPIFSM_Start_o        start request to the SPI FSM (combinational)
//   SPIFSM_Done_i         SPI FSM idle/done, 0 while a transaction runs
//   SPIFSM_Byte0_i        low result byte
//   SPIFSM_Byte1_i        high result byte
//   ParamCounterPreset_i  idle cycles between measurements
//   ParamThreshold_i      unsigned report threshold
// ---------------------------------------------------------------------------
module adt7310_scheduler #(
   parameter int DataWidth = 8
) (
   input  logic                   Clk_i,
   input  logic                   Reset_i,
   input  logic                   Enable_i,
   output logic                   CpuIntr_o,
   output logic [2*DataWidth-1:0] SensorValue_o,
   output logic                   SPIFSM_Start_o,
   input  logic                   SPIFSM_Done_i,
   input  logic [DataWidth-1:0]   SPIFSM_Byte0_i,
   input  logic [DataWidth-1:0]   SPIFSM_Byte1_i,
   input  logic [31:0]            ParamCounterPreset_i,
   input  logic [15:0]            ParamThreshold_i
);

   localparam logic [1:0] stDisabled = 2'd0;
   localparam logic [1:0] stIdle     = 2'd1;
   localparam logic [1:0] stXfer     = 2'd2;
   localparam logic [1:0] stNotify   = 2'd3;

   logic [1:0]                   State;
   logic [31:0]                  Timer;
   logic [2*DataWidth-1:0]       Stored;
   logic                         FirstFlag;
   logic                         Armed;
   logic signed [2*DataWidth-1:0] NewValue;
   logic                         Report;

   // Magnitude of the 17-bit signed difference a - b. The extra bit keeps
   // the full range of two 16-bit signed operands without overflow.
   function automatic logic [16:0] abs_diff(input logic signed [15:0] a,
                                            input logic signed [15:0] b);
      logic signed [16:0] d;
      d = $signed({a[15], a}) - $signed({b[15], b});
      if (d[16])
         abs_diff = $unsigned(-d);
      else
         abs_diff = $unsigned(d);
   endfunction

   assign NewValue      = $signed({SPIFSM_Byte1_i, SPIFSM_Byte0_i});
   assign Report        = FirstFlag ||
                          (abs_diff(NewValue, $signed(Stored)) > {1'b0, ParamThreshold_i});
   assign SensorValue_o = Stored;

   // Start is asserted for exactly the stIdle cycle in which the timer has
   // run down; the FSM leaves stIdle on the following edge.
   assign SPIFSM_Start_o = (State == stIdle) && Enable_i && (Timer == 32'd0);

   always_ff @(posedge Clk_i or posedge Reset_i) begin
      if (Reset_i) begin
         State     <= stDisabled;
         Timer     <= 32'd0;
         Stored    <= '0;
         CpuIntr_o <= 1'b0;
         FirstFlag <= 1'b1;
         Armed     <= 1'b0;
      end else begin
         // Armed holds the FSM still for the first edge after reset release,
         // so no state change can happen before the second rising edge.
         Armed     <= 1'b1;
         CpuIntr_o <= 1'b0;
         if (Armed) begin
            case (State)
               stDisabled: begin
                  Timer     <= ParamCounterPreset_i;
                  FirstFlag <= 1'b1;
                  if (Enable_i)
                     State <= stIdle;
               end
               stIdle: begin
                  if (!Enable_i) begin
                     State     <= stDisabled;
                     FirstFlag <= 1'b1;
                  end else if (Timer != 32'd0) begin
                     Timer <= Timer - 32'd1;
                  end else begin
                     State <= stXfer;
                  end
               end
               stXfer: begin
                  // A running transaction is never aborted; when it finishes
                  // with the block disabled the result is simply dropped.
                  if (SPIFSM_Done_i) begin
                     Timer <= ParamCounterPreset_i;
                     if (!Enable_i) begin
                        State     <= stDisabled;
                        FirstFlag <= 1'b1;
                     end else if (Report) begin
                        Stored    <= NewValue;
                        CpuIntr_o <= 1'b1;
                        FirstFlag <= 1'b0;
                        State     <= stNotify;
                     end else begin
                        State <= stIdle;
                     end
                  end
               end
               default: begin
                  if (Enable_i) begin
                     State <= stIdle;
                  end else begin
                     State     <= stDisabled;
                     FirstFlag <= 1'b1;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_adt7310_scheduler.sv
module tb_adt7310_scheduler;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        Enable;
   logic        CpuIntr;
   logic [15:0] SensorValue;
   logic        Start;
   logic        Done;
   logic [7:0]  Byte0;
   logic [7:0]  Byte1;
   logic [31:0] Preset;
   logic [15:0] Thr;

   int tests = 0;
   int fails = 0;

   // Reference state: last reported value and whether the next reading is
   // the first one after reset / re-enable.
   logic [15:0] stored_m;
   logic        first_m;

   always #5 Clk = ~Clk;

   adt7310_scheduler #(.DataWidth(8)) dut (
      .Clk_i               (Clk),
      .Reset_i             (Reset),
      .Enable_i            (Enable),
      .CpuIntr_o           (CpuIntr),
      .SensorValue_o       (SensorValue),
      .SPIFSM_Start_o      (Start),
      .SPIFSM_Done_i       (Done),
      .SPIFSM_Byte0_i      (Byte0),
      .SPIFSM_Byte1_i      (Byte1),
      .ParamCounterPreset_i(Preset),
      .ParamThreshold_i    (Thr)
   );

   task automatic tick;
      @(negedge Clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Report decision from plain integer arithmetic on the two readings.
   function automatic logic predict(input logic [15:0] nv, input logic [15:0] thr);
      int d;
      d = int'($signed(nv)) - int'($signed(stored_m));
      if (d < 0) d = -d;
      return first_m || (d > int'(thr));
   endfunction

   // Count negedges until Start is seen (0 if already high now).
   task automatic wait_start(input string tag, input int exp);
      int n;
      n = 0;
      while (Start !== 1'b1 && n < exp + 20) begin
         tick;
         n++;
      end
      check(tag, 32'(n), 32'(exp));
   endtask

   // Called at the negedge where Start is high. Plays the SPI FSM for len
   // cycles, returns nv, checks the outcome and the gap to the next start.
   task automatic do_meas(input string tag, input logic [15:0] nv, input int len,
                          input logic [15:0] thr, input logic [31:0] next_p,
                          input logic drop_en);
      logic rep;
      Done = 1'b0;
      Thr  = 16'($urandom);
      tick;
      check({tag, "_start1cyc"}, 32'(Start), 32'd0);
      if (drop_en) Enable = 1'b0;
      repeat (len - 1) tick;
      {Byte1, Byte0} = nv;
      Done   = 1'b1;
      Thr    = thr;
      Preset = next_p;
      rep = drop_en ? 1'b0 : predict(nv, thr);
      if (drop_en) begin
         first_m = 1'b1;
      end else if (rep) begin
         stored_m = nv;
         first_m  = 1'b0;
      end
      tick;
      check({tag, "_intr"}, 32'(CpuIntr), 32'(rep));
      check({tag, "_value"}, 32'(SensorValue), 32'(stored_m));
      if (!drop_en) begin
         if (rep) begin
            tick;
            check({tag, "_intrclr"}, 32'(CpuIntr), 32'd0);
         end
         Preset = $urandom;
         Thr    = 16'($urandom);
         wait_start({tag, "_gap"}, int'(next_p));
      end
   endtask

   initial begin
      int n;
      int pulses;
      logic [15:0] nv;
      Reset = 1'b1; Enable = 1'b0; Done = 1'b1; Byte0 = '0; Byte1 = '0;
      Preset = 32'd5; Thr = 16'd16; stored_m = '0; first_m = 1'b1;
      repeat (2) tick;
      check("rst_start", 32'(Start), 32'd0);
      check("rst_intr", 32'(CpuIntr), 32'd0);
      check("rst_value", 32'(SensorValue), 32'd0);

      // One held edge after release, then 5 idle cycles, start on the 6th.
      Reset = 1'b0; Enable = 1'b1;
      wait_start("p5_first_start", 7);
      do_meas("m0190", 16'h0190, 3, 16'd16, 32'd1, 1'b0);
      do_meas("thr16_nopulse", 16'h0180, 2, 16'd16, 32'd2, 1'b0);
      do_meas("thr15_pulse", 16'h0180, 4, 16'd15, 32'd0, 1'b0);
      do_meas("set5", 16'h0005, 1, 16'd0, 32'd0, 1'b0);
      do_meas("neg5_d10", 16'hFFFB, 2, 16'd9, 32'd0, 1'b0);
      do_meas("b2b_a", 16'hFFFB, 2, 16'd0, 32'd0, 1'b0);
      do_meas("b2b_b", 16'hFFFA, 1, 16'd1, 32'd3, 1'b0);

      // Disable mid-transaction, then re-enable with an unchanged reading.
      do_meas("drop_en", 16'h1234, 3, 16'd0, 32'd4, 1'b1);
      pulses = 0;
      repeat (4) begin
         tick;
         if (Start !== 1'b0 || CpuIntr !== 1'b0) pulses++;
      end
      check("disabled_quiet", 32'(pulses), 32'd0);
      Preset = 32'd2; Enable = 1'b1;
      wait_start("reenable_start", 3);
      do_meas("first_after_en", stored_m, 2, 16'd0, 32'd1, 1'b0);

      for (int i = 0; i < 25; i++) begin
         if ($urandom_range(0, 3) == 0)
            nv = 16'($urandom);
         else
            nv = stored_m + 16'($urandom_range(0, 40)) - 16'd20;
         do_meas("rand", nv, int'($urandom_range(1, 5)), 16'($urandom_range(0, 30)),
                 32'($urandom_range(0, 6)), 1'b0);
      end

      // Reset in the middle of a transaction.
      Done = 1'b0;
      tick;
      tick;
      Reset = 1'b1;
      #1;
      check("midrst_start", 32'(Start), 32'd0);
      check("midrst_intr", 32'(CpuIntr), 32'd0);
      check("midrst_value", 32'(SensorValue), 32'd0);
      Done = 1'b1;
      stored_m = '0; first_m = 1'b1;
      tick;
      Reset = 1'b0; Preset = 32'd3;
      n = 0; pulses = 0;
      while (Start !== 1'b1 && n < 30) begin
         tick;
         n++;
         if (CpuIntr !== 1'b0) pulses++;
      end
      check("postrst_start", 32'(n), 32'd5);
      check("postrst_nopulse", 32'(pulses), 32'd0);
      do_meas("postrst_first", 16'h0042, 2, 16'hFFFF, 32'd0, 1'b0);

      // Largest preset must count down, not wrap into an early start.
      Enable = 1'b0;
      Preset = 32'hFFFF_FFFF;
      repeat (2) tick;
      Enable = 1'b1;
      pulses = 0;
      repeat (60) begin
         tick;
         if (Start !== 1'b0) pulses++;
      end
      check("maxpreset_nostart", 32'(pulses), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/adt7310_scheduler.md
ADT7310_SCHEDULER -- requirements
Module: adt7310_scheduler

Interface
REQ-001 SHALL have parameter DataWidth, default 8, meaning the width of each SPI FSM result byte; the value is fixed at 8 for this block.
REQ-002 SHALL have port Clk_i  input  1  system clock; all state changes occur on its rising edge.
REQ-003 SHALL have port Reset_i  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port Enable_i  input  1  level; 1 runs periodic measurements, 0 parks the block.
REQ-005 SHALL have port CpuIntr_o  output  1  registered one-cycle pulse marking a new reported value.
REQ-006 SHALL have port SensorValue_o  output  16  last reported value, {Byte1,Byte0}, two's complement.
REQ-007 SHALL have port SPIFSM_Start_o  output  1  start request to the ADT7310 SPI transaction FSM.
REQ-008 SHALL have port SPIFSM_Done_i  input  1  SPI FSM idle/done; 0 while a transaction runs.
REQ-009 SHALL have port SPIFSM_Byte0_i  input  8  low result byte from the SPI FSM.
REQ-010 SHALL have port SPIFSM_Byte1_i  input  8  high result byte from the SPI FSM.
REQ-011 SHALL have port ParamCounterPreset_i  input  32  idle cycles between measurements.
REQ-012 SHALL have port ParamThreshold_i  input  16  unsigned report threshold.

Function
REQ-013 SHALL implement the states stDisabled, stIdle, stXfer and stNotify.
REQ-014 In stDisabled, the period timer SHALL load ParamCounterPreset_i every cycle.
REQ-015 In stDisabled, Enable_i=1 SHALL move the FSM to stIdle on the next edge.
REQ-016 In stIdle, Enable_i=0 SHALL move the FSM to stDisabled.
REQ-017 In stIdle with Enable_i=1 and timer != 0, the timer SHALL decrement by 1 each cycle.
REQ-018 In stIdle with Enable_i=1 and timer == 0, SPIFSM_Start_o SHALL be 1 combinationally for exactly that cycle and the next state SHALL be stXfer.
REQ-019 Preset P SHALL yield P idle cycles followed by the start cycle; P=0 SHALL start on the first stIdle cycle; P=0xFFFFFFFF SHALL count without wrap.
REQ-020 SPIFSM_Start_o SHALL be 0 in every state other than stIdle.
REQ-021 In stXfer, the FSM SHALL wait for SPIFSM_Done_i=1; Done_i=0 in the cycle after start is normal and SHALL be ignored.
REQ-022 When Done_i=1 in stXfer, the FSM SHALL sample New={Byte1_i,Byte0_i}.
REQ-023 On that sample, the FSM SHALL compute D=|New-Stored| as a 17-bit signed difference taken to its magnitude.
REQ-024 A report SHALL occur when FirstFlag=1 or D > ParamThreshold_i (strictly greater).
REQ-025 On a report, Stored, SensorValue_o and CpuIntr_o=1 SHALL be registered on the same edge, FirstFlag SHALL clear, and the next state SHALL be stNotify.
REQ-026 With no report, the next state SHALL be stIdle, Stored SHALL be unchanged and no pulse SHALL occur.
REQ-027 On leaving stXfer, the timer SHALL reload ParamCounterPreset_i.
REQ-028 stNotify SHALL last one cycle; CpuIntr_o SHALL return to 0 on exit.
REQ-029 stNotify SHALL go to stIdle if Enable_i=1, else to stDisabled.
REQ-030 Enable_i=0 during stXfer SHALL NOT abort the transaction; on Done_i the FSM SHALL discard the result (no compare, no report) and go to stDisabled.
REQ-031 Every transition into stDisabled SHALL set FirstFlag=1, so the first measurement after re-enable always reports.
REQ-032 Parameter inputs SHALL be sampled only at timer load and at compare time; changes at other times SHALL have no effect.

Reset
REQ-033 Reset_i=1 SHALL force, asynchronously: state stDisabled, timer 0, Stored 0, SensorValue_o 0, CpuIntr_o 0, SPIFSM_Start_o 0, FirstFlag 1.
REQ-034 Reset during stXfer SHALL abandon the transaction without a report; the SPI FSM reset SHALL be driven from the same source.
REQ-035 After Reset_i falls, the first transition SHALL be no earlier than the second rising edge.

Verification
REQ-036 SHALL cover: Preset=5, Enable_i=1 -> Start_o high exactly on the 6th stIdle cycle; Done_i returned with 0x0190 -> CpuIntr_o one-cycle pulse, SensorValue_o=0x0190.
REQ-037 SHALL cover: Stored=0x0190, Threshold=16, New=0x0180 -> no pulse; Threshold=15 -> pulse, SensorValue_o=0x0180.
REQ-038 SHALL cover: Stored=0x0005, New=0xFFFB (-5), Threshold=9 -> D=10, pulse.
REQ-039 SHALL cover: Enable_i dropped during stXfer -> transaction completes, no pulse, stDisabled; re-enable with New equal to Stored -> pulse (FirstFlag).
REQ-040 SHALL cover: Preset=0 -> back-to-back starts separated only by transaction length and one reload cycle.
REQ-041 SHALL cover: Reset_i asserted mid-stXfer -> all outputs 0 immediately, no pulse after release.
